// File: rtl/i2c_cmd_seq_pkg.sv
// Shared types and helpers for the i2c_ctrl burst command sequencer.
package i2c_cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_END,
        S_GAP
    } state_t;

    // Wide enough for the default 2,000,000-cycle transfer timeout.
    localparam int CNT_W = 22;

    // 8-bit address mode keeps the upper byte at zero and wraps the low byte.
    function automatic logic [15:0] next_addr(input logic [15:0] addr, input logic addr2);
        next_addr = addr2 ? (addr + 16'd1) : {8'h00, addr[7:0] + 8'd1};
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter with a zero flag; the sequencer reuses it for the
// start hold, the transfer timeout and the inter-byte gap.
module i2c_seq_timer #(
    parameter int W = 22
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/i2c_cmd_seq.sv
// Burst command sequencer: splits one (addr, len, dir) request into
// single-byte i2c_ctrl transactions with start hold, timeout and write-cycle gap.
module i2c_cmd_seq
    import i2c_cmd_seq_pkg::*;
#(
    parameter int unsigned START_HOLD = 50,
    parameter int unsigned WR_GAP     = 250000,
    parameter int unsigned RD_GAP     = 50,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic        i_req_addr2,
    input  logic [15:0] i_req_addr,
    input  logic [7:0]  i_req_len,
    input  logic        i_wdata_valid,
    output logic        o_wdata_ready,
    input  logic [7:0]  i_wdata,
    output logic        o_rdata_valid,
    output logic [7:0]  o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic        o_i2c_start,
    output logic        o_addr_num,
    output logic [15:0] o_byte_addr,
    output logic [7:0]  o_wr_data,
    input  logic        i_i2c_end,
    input  logic [7:0]  i_rd_data
);

    // The timeout window is measured from the i2c_start rise, so the part
    // already spent holding i2c_start is subtracted from the WAIT_END load.
    localparam logic [CNT_W-1:0] LD_START = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_TOUT  = CNT_W'(TIMEOUT - START_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_WGAP  = CNT_W'(WR_GAP - 1);
    localparam logic [CNT_W-1:0] LD_RGAP  = CNT_W'(RD_GAP - 1);

    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [15:0] r_byte_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_rdata;
    logic        r_req_ready;
    logic        r_wdata_ready;
    logic        r_rdata_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_wr_en;
    logic        r_rd_en;
    logic        r_i2c_start;
    logic        r_addr_num;
    logic        r_end_d;

    logic             w_accept;
    logic             w_end_rise;
    logic             w_last;
    logic             w_tmr_zero;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;

    assign w_accept   = i_req_valid & r_req_ready;
    assign w_end_rise = i_i2c_end & ~r_end_d;
    assign w_last     = (r_cnt == 9'd1);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = LD_START;
        case (r_state)
            S_IDLE:   w_tmr_load = w_accept & ~i_req_wr;
            S_FETCH:  w_tmr_load = i_wdata_valid;
            S_START: begin
                w_tmr_load = w_tmr_zero;
                w_tmr_val  = LD_TOUT;
            end
            S_WAIT_END: begin
                w_tmr_load = w_end_rise;
                w_tmr_val  = r_wr_en ? LD_WGAP : LD_RGAP;
            end
            S_GAP:    w_tmr_load = w_tmr_zero & ~w_last & r_rd_en;
            default:  w_tmr_load = 1'b0;
        endcase
    end

    i2c_seq_timer #(
        .W(CNT_W)
    ) u_timer (
        .i_clk      (i_sys_clk),
        .i_rst      (i_sys_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_byte_addr   <= '0;
            r_wr_data     <= '0;
            r_rdata       <= '0;
            r_req_ready   <= 1'b1;
            r_wdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_i2c_start   <= 1'b0;
            r_addr_num    <= 1'b0;
            r_end_d       <= 1'b0;
        end else begin
            r_end_d       <= i_i2c_end;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;
            // Ready reappears one cycle after the state returns to IDLE.
            r_req_ready   <= (r_state == S_IDLE) & ~w_accept;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr_en     <= i_req_wr;
                        r_rd_en     <= ~i_req_wr;
                        r_addr_num  <= i_req_addr2;
                        r_byte_addr <= i_req_addr;
                        r_cnt       <= {(i_req_len == 8'd0), i_req_len};
                        r_busy      <= 1'b1;
                        if (i_req_wr) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state     <= S_START;
                            r_i2c_start <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (i_wdata_valid) begin
                        r_wdata_ready <= 1'b1;
                        r_wr_data     <= i_wdata;
                        r_i2c_start   <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    if (w_tmr_zero) begin
                        r_i2c_start <= 1'b0;
                        r_state     <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (w_end_rise) begin
                        if (r_rd_en) begin
                            r_rdata       <= i_rd_data;
                            r_rdata_valid <= 1'b1;
                        end
                        r_state <= S_GAP;
                    end else if (w_tmr_zero) begin
                        r_err   <= 1'b1;
                        r_wr_en <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (w_tmr_zero) begin
                        r_cnt <= r_cnt - 9'd1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_wr_en <= 1'b0;
                            r_rd_en <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_addr <= next_addr(r_byte_addr, r_addr_num);
                            if (r_wr_en) begin
                                r_state <= S_FETCH;
                            end else begin
                                r_state     <= S_START;
                                r_i2c_start <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_wdata_ready = r_wdata_ready;
    assign o_rdata_valid = r_rdata_valid;
    assign o_rdata       = r_rdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_wr_en       = r_wr_en;
    assign o_rd_en       = r_rd_en;
    assign o_i2c_start   = r_i2c_start;
    assign o_addr_num    = r_addr_num;
    assign o_byte_addr   = r_byte_addr;
    assign o_wr_data     = r_wr_data;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq with an i2c_ctrl responder, a write-data
// source and a transaction monitor compared against spec-derived expectations.
module tb_i2c_cmd_seq;

    localparam int SH = 50;
    localparam int WG = 200;
    localparam int RG = 20;
    localparam int TO = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_addr2 = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        wdata_valid;
    logic [7:0]  wdata;
    logic        i2c_end;
    logic [7:0]  rd_data;
    logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_busy, o_done, o_err;
    logic        o_wr_en, o_rd_en, o_i2c_start, o_addr_num;
    logic [7:0]  o_rdata, o_wr_data;
    logic [15:0] o_byte_addr;

    always #5 clk = ~clk;

    i2c_cmd_seq #(
        .START_HOLD (SH),
        .WR_GAP     (WG),
        .RD_GAP     (RG),
        .TIMEOUT    (TO)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_wr      (req_wr),
        .i_req_addr2   (req_addr2),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_wdata_valid (wdata_valid),
        .o_wdata_ready (o_wdata_ready),
        .i_wdata       (wdata),
        .o_rdata_valid (o_rdata_valid),
        .o_rdata       (o_rdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_wr_en       (o_wr_en),
        .o_rd_en       (o_rd_en),
        .o_i2c_start   (o_i2c_start),
        .o_addr_num    (o_addr_num),
        .o_byte_addr   (o_byte_addr),
        .o_wr_data     (o_wr_data),
        .i_i2c_end     (i2c_end),
        .i_rd_data     (rd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int bid      = 0;

    // Stimulus controls shared with the background processes.
    logic [7:0] wsrc_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] data_q[$];
    int  src_delay   = 0;
    bit  ctrl_silent = 1'b0;
    bit  glitch_en   = 1'b0;
    bit  poke_busy   = 1'b0;
    bit  mon_exp_wr  = 1'b0;

    // Monitor logs.
    logic [15:0] st_addr_q[$];
    logic [7:0]  st_wd_q[$];
    logic        st_an_q[$];
    int          hold_q[$];
    logic [15:0] end_addr_q[$];
    logic [7:0]  end_wd_q[$];
    logic [7:0]  rdv_q[$];
    int cyc = 0, hold = 0, first_st_cyc = 0, acc_cyc = 0, err_cyc = 0;
    int done_cnt = 0, err_cnt = 0, en_bad = 0;
    bit p_start = 0, p_end = 0, p_busy = 0, pend_post = 0;
    bit at_rdy = 0, at_busy = 0, post_rdy = 0;
    logic [1:0] at_en = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-data source: holds a byte valid until the sequencer's ready pulse.
    initial begin
        wdata_valid = 1'b0;
        wdata       = '0;
        forever begin
            @(negedge clk);
            if (o_wdata_ready && wsrc_q.size() > 0) void'(wsrc_q.pop_front());
            if (src_delay > 0) begin
                src_delay--;
                wdata_valid = 1'b0;
            end else if (wsrc_q.size() > 0) begin
                wdata_valid = 1'b1;
                wdata       = wsrc_q[0];
            end else begin
                wdata_valid = 1'b0;
            end
        end
    end

    // i2c_ctrl responder: pulses i2c_end some cycles after i2c_start falls.
    initial begin
        i2c_end = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge o_i2c_start);
            if (!ctrl_silent) begin
                repeat ($urandom_range(2, 12)) @(negedge clk);
                rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'($urandom);
                i2c_end = 1'b1;
                repeat (3) @(negedge clk);
                i2c_end = 1'b0;
                if (glitch_en) begin
                    repeat (2) @(negedge clk);
                    i2c_end = 1'b1;
                    @(negedge clk);
                    i2c_end = 1'b0;
                end
            end
        end
    end

    // Monitor: logs transactions on the falling edge, away from DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_i2c_start && !p_start) begin
                if (st_addr_q.size() == 0) first_st_cyc = cyc;
                st_addr_q.push_back(o_byte_addr);
                st_wd_q.push_back(o_wr_data);
                st_an_q.push_back(o_addr_num);
                hold = 0;
            end
            if (o_i2c_start) hold++;
            if (!o_i2c_start && p_start) hold_q.push_back(hold);
            if (i2c_end && !p_end && end_addr_q.size() < st_addr_q.size()) begin
                end_addr_q.push_back(o_byte_addr);
                end_wd_q.push_back(o_wr_data);
            end
            if (o_rdata_valid) rdv_q.push_back(o_rdata);
            if (o_busy && !p_busy) acc_cyc = cyc;
            if (o_busy && (o_wr_en !== mon_exp_wr || o_rd_en !== !mon_exp_wr)) en_bad++;
            if (pend_post) begin
                post_rdy  = o_req_ready;
                pend_post = 1'b0;
            end
            if (o_done || o_err) begin
                at_rdy    = o_req_ready;
                at_busy   = o_busy;
                at_en     = {o_wr_en, o_rd_en};
                pend_post = 1'b1;
            end
            if (o_done) done_cnt++;
            if (o_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            p_start = o_i2c_start;
            p_end   = i2c_end;
            p_busy  = o_busy;
        end
    end

    task automatic clear_logs();
        st_addr_q.delete(); st_wd_q.delete(); st_an_q.delete(); hold_q.delete();
        end_addr_q.delete(); end_wd_q.delete(); rdv_q.delete();
        done_cnt = 0; err_cnt = 0; en_bad = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".flags"}, {o_busy, o_done, o_err, o_wr_en, o_rd_en, o_i2c_start,
                                o_addr_num, o_wdata_ready, o_rdata_valid}, 0);
        check({tag, ".byte_addr"}, o_byte_addr, 0);
        check({tag, ".wr_data"}, o_wr_data, 0);
        check({tag, ".rdata"}, o_rdata, 0);
        check({tag, ".req_ready"}, o_req_ready, 1);
    endtask

    task automatic issue_req(input bit wr, input bit a2, input logic [15:0] addr, input logic [7:0] len);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr2 = a2;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        check($sformatf("b%0d.busy_after_accept", bid), o_busy, 1);
        check($sformatf("b%0d.ready_after_accept", bid), o_req_ready, 0);
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        int d0 = done_cnt;
        int e0 = err_cnt;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (poke_busy && k == 100) begin
                req_valid = 1'b1;
                req_wr    = ~req_wr;
                req_len   = 8'd77;
            end
            if (k == 110) req_valid = 1'b0;
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Runs one burst and compares every logged transaction with the reference.
    task automatic run_burst(input bit wr, input bit a2, input logic [15:0] addr, input logic [7:0] len);
        int n = (len == 8'd0) ? 256 : int'(len);
        logic [7:0] exp_d[$];
        logic [15:0] exp_a;
        bit ok;
        bid++;
        while (data_q.size() < n) data_q.push_back(8'($urandom));
        exp_d = data_q;
        data_q.delete();
        clear_logs();
        mon_exp_wr = wr;
        if (wr) wsrc_q = exp_d; else rd_q = exp_d;
        issue_req(wr, a2, addr, len);
        wait_finish(40000, ok);
        check($sformatf("b%0d.finished", bid), ok, 1);
        check($sformatf("b%0d.done_cnt", bid), done_cnt, 1);
        check($sformatf("b%0d.err_cnt", bid), err_cnt, 0);
        check($sformatf("b%0d.start_cnt", bid), st_addr_q.size(), n);
        check($sformatf("b%0d.rdv_cnt", bid), rdv_q.size(), wr ? 0 : n);
        for (int i = 0; i < n && i < st_addr_q.size() && i < end_addr_q.size() && i < hold_q.size(); i++) begin
            if (a2) exp_a = 16'(int'(addr) + i);
            else if (i == 0) exp_a = addr;
            else exp_a = {8'h00, 8'(int'(addr[7:0]) + i)};
            check($sformatf("b%0d.addr%0d", bid, i), st_addr_q[i], exp_a);
            check($sformatf("b%0d.addr_end%0d", bid, i), end_addr_q[i], exp_a);
            check($sformatf("b%0d.hold%0d", bid, i), hold_q[i], SH);
            check($sformatf("b%0d.addr_num%0d", bid, i), st_an_q[i], a2);
            if (wr) begin
                check($sformatf("b%0d.wr_data%0d", bid, i), st_wd_q[i], exp_d[i]);
                check($sformatf("b%0d.wr_data_end%0d", bid, i), end_wd_q[i], exp_d[i]);
            end else if (i < rdv_q.size()) begin
                check($sformatf("b%0d.rdata%0d", bid, i), rdv_q[i], exp_d[i]);
            end
        end
        check($sformatf("b%0d.en_stable", bid), en_bad, 0);
        check($sformatf("b%0d.ready_at_done", bid), at_rdy, 0);
        check($sformatf("b%0d.busy_at_done", bid), at_busy, 0);
        check($sformatf("b%0d.en_at_done", bid), at_en, 0);
        check($sformatf("b%0d.ready_after_done", bid), post_rdy, 1);
    endtask

    initial begin
        bit ok;
        int d0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Directed write at 0x55 (8-bit), with a request poked in while busy.
        data_q = '{8'h89, 8'h9A, 8'hAB};
        poke_busy = 1'b1;
        run_burst(1'b1, 1'b0, 16'h0055, 8'd3);
        poke_busy = 1'b0;

        // Directed read at 0x1234 (16-bit).
        data_q = '{8'hC3, 8'h3C};
        run_burst(1'b0, 1'b1, 16'h1234, 8'd2);

        // Address wrap in both modes.
        run_burst(1'b1, 1'b0, 16'h00FE, 8'd3);
        run_burst(1'b1, 1'b1, 16'hFFFF, 8'd2);

        // Randomized bursts with a spurious i2c_end pulse during each gap.
        glitch_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            run_burst(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom_range(1, 5)));
        end
        glitch_en = 1'b0;

        // len=0 means 256 bytes.
        run_burst(1'b0, 1'b1, 16'($urandom), 8'd0);

        // Timeout: responder stays silent.
        ctrl_silent = 1'b1;
        bid++;
        clear_logs();
        mon_exp_wr = 1'b0;
        issue_req(1'b0, 1'b0, 16'h0010, 8'd1);
        wait_finish(8000, ok);
        check("tout.finished", ok, 1);
        check("tout.err_cnt", err_cnt, 1);
        check("tout.done_cnt", done_cnt, 0);
        check("tout.err_latency", err_cyc - first_st_cyc, TO);
        check("tout.en_at_err", at_en, 0);
        check("tout.busy_at_err", at_busy, 0);
        check("tout.ready_at_err", at_rdy, 0);
        check("tout.ready_after_err", post_rdy, 1);
        check("tout.no_rdata", rdv_q.size(), 0);
        ctrl_silent = 1'b0;
        rd_q.delete();

        // Reset during the gap after byte 2 of a 4-byte write.
        bid++;
        clear_logs();
        mon_exp_wr = 1'b1;
        wsrc_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue_req(1'b1, 1'b0, 16'h0040, 8'd4);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (end_addr_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst.reached_byte2", ok, 1);
        repeat (10) @(negedge clk);
        check("rst.busy_in_gap", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst.mid_burst");
        rst = 1'b0;
        wsrc_q.delete();
        d0 = done_cnt;
        repeat (400) @(negedge clk);
        check("rst.no_done", done_cnt - d0, 0);
        check("rst.no_err", err_cnt, 0);
        check("rst.no_more_starts", st_addr_q.size(), 2);
        run_burst(1'b0, 1'b1, 16'h8000, 8'd2);

        // Write data withheld for 300+ cycles in FETCH.
        src_delay = 310;
        run_burst(1'b1, 1'b1, 16'h0200, 8'd1);
        check("stall.no_early_start", (first_st_cyc - acc_cyc) >= 300, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
